// File: rtl/dmg_lcd_fetch.sv
// dmg_lcd_fetch: prefetches the next visible 2-bpp line into a ping-pong buffer and serves pixels; optional palette via DMG_LCD_FETCH_PALETTE_EN
module dmg_lcd_fetch #(
    parameter int          VTOT      = 170,
    parameter int          VPIXELEND = 160,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk_8m,
    input  logic        rst,
    input  logic [7:0]  cur_xpos,
    input  logic [7:0]  cur_ypos,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    input  logic [7:0]  palette,
    output logic [1:0]  pix,
    output logic        underrun,
    input  logic        underrun_clr
);
    localparam logic [8:0] VEND9 = 9'(VPIXELEND);
    localparam logic [7:0] VTOT8 = 8'(VTOT);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  ypos_q, pend_q, start_line, tgt, sel_byte;
    logic [8:0]  ynext;
    logic [5:0]  idx_q;
    logic        boot_q, bank_q, has_tgt, start, wr_en, done;
    logic        active, ready, bank;
    logic [1:0]  valid_q, raw, mapped;
    logic [7:0]  tag_q [2];
    logic [7:0]  line_buf [2][40];

    assign ynext   = {1'b0, cur_ypos} + 9'd1;
    assign tgt     = (cur_ypos == VTOT8) ? 8'd0 : ynext[7:0];
    assign has_tgt = (cur_ypos != ypos_q) && ((ynext < VEND9) || (cur_ypos == VTOT8));
    assign mem_req = (state_q != IDLE);

    // fetch sequencing: start, per-byte write, and abandoning a stale line after its pending ack
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        start_line = tgt;
        wr_en      = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (has_tgt || boot_q) begin
                    start      = 1'b1;
                    start_line = has_tgt ? tgt : 8'd0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (has_tgt && mem_ack) begin
                    start = 1'b1;
                end else if (has_tgt) begin
                    state_d = DRAIN;
                end else if (mem_ack) begin
                    wr_en   = 1'b1;
                    done    = (idx_q == 6'd39);
                    state_d = done ? IDLE : FETCH;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    start      = 1'b1;
                    start_line = has_tgt ? tgt : pend_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; reset abandons any outstanding request
    always_ff @(posedge clk_8m or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // line tracking, bank tags/valids and the address counter
    always_ff @(posedge clk_8m or posedge rst) begin
        if (rst) begin
            ypos_q   <= 8'd0;
            pend_q   <= 8'd0;
            boot_q   <= 1'b1;
            bank_q   <= 1'b0;
            idx_q    <= 6'd0;
            mem_addr <= 16'd0;
            valid_q  <= 2'b00;
            tag_q    <= '{default: 8'd0};
        end else begin
            ypos_q <= cur_ypos;
            boot_q <= 1'b0;
            if (has_tgt) pend_q <= tgt;
            if (start) begin
                bank_q                 <= start_line[0];
                idx_q                  <= 6'd0;
                mem_addr               <= BASE_ADDR + 16'(start_line) * 16'd40;
                valid_q[start_line[0]] <= 1'b0;
                tag_q[start_line[0]]   <= start_line;
            end else if (wr_en) begin
                idx_q    <= idx_q + 6'd1;
                mem_addr <= mem_addr + 16'd1;
            end
            if (done) valid_q[bank_q] <= 1'b1;
        end
    end

    // line storage has no reset; validity is tracked separately
    always_ff @(posedge clk_8m) begin
        if (wr_en) line_buf[bank_q][idx_q] <= mem_data;
    end

    assign active   = ({1'b0, cur_xpos} < VEND9) && ({1'b0, cur_ypos} < VEND9);
    assign bank     = cur_ypos[0];
    assign ready    = valid_q[bank] && (tag_q[bank] == cur_ypos);
    assign sel_byte = line_buf[bank][active ? cur_xpos[7:2] : 6'd0];
    assign raw      = 2'(sel_byte >> {~cur_xpos[1:0], 1'b0});

`ifdef DMG_LCD_FETCH_PALETTE_EN
    assign mapped = 2'(palette >> {raw, 1'b0});
`else
    logic unused_palette;
    assign unused_palette = ^palette;
    assign mapped = raw;
`endif

    // registered pixel and sticky underrun (set beats clear)
    always_ff @(posedge clk_8m or posedge rst) begin
        if (rst) begin
            pix      <= 2'b11;
            underrun <= 1'b0;
        end else begin
            pix      <= (active && ready) ? mapped : 2'b11;
            underrun <= (active && !ready) ? 1'b1 : underrun_clr ? 1'b0 : underrun;
        end
    end
endmodule

// File: tb/tb_dmg_lcd_fetch.sv
// tb_dmg_lcd_fetch: scoreboard bench for the line prefetcher with a latency-programmable memory model
module tb_dmg_lcd_fetch;
    localparam logic [15:0] BASE = 16'h8000;
    localparam logic [7:0]  PAL  = 8'b00011011;
    localparam int K_PIX = 0, K_UND = 1, K_REQ = 2, K_ADDR = 3, K_TO = 4;

    typedef struct {
        int          kind;
        logic [15:0] val;
        int          aux;
        string       name;
    } item_t;

    logic        clk_8m, rst, mem_req, mem_ack, underrun, underrun_clr;
    logic [7:0]  cur_xpos, cur_ypos, mem_data, palette;
    logic [15:0] mem_addr;
    logic [1:0]  pix;

    item_t       exp_q[$];
    logic [15:0] exp_a[$];
    int          n_chk = 0, n_fail = 0, lat = 0, cnt = 0, k;
    logic        chk_addr = 1'b1;

    dmg_lcd_fetch #(.BASE_ADDR(BASE)) dut (
        .clk_8m(clk_8m), .rst(rst), .cur_xpos(cur_xpos), .cur_ypos(cur_ypos),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .palette(palette), .pix(pix), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    initial clk_8m = 1'b0;
    always #5 clk_8m = ~clk_8m;

    // memory: data = addr[7:0], ack after lat idle cycles of a held request
    initial begin
        mem_ack  = 1'b0;
        mem_data = 8'd0;
        forever begin
            @(posedge clk_8m); #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (cnt >= lat) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_addr[7:0];
                    cnt      = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    // monitor: compare queued expectations and every acknowledged address
    always @(negedge clk_8m) begin
        item_t       it;
        logic [15:0] act, ea;
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            case (it.kind)
                K_PIX:   act = {14'd0, pix};
                K_UND:   act = {15'd0, underrun};
                K_REQ:   act = {15'd0, mem_req};
                K_ADDR:  act = mem_addr;
                default: act = 16'(it.aux);
            endcase
            n_chk++;
            if (act !== it.val) begin
                n_fail++;
                $display("FAIL %s: actual %0h required %0h", it.name, act, it.val);
            end
        end
        if (mem_ack && mem_req && chk_addr) begin
            n_chk++;
            if (exp_a.size() == 0) begin
                n_fail++;
                $display("FAIL addr: actual request %0h required none", mem_addr);
            end else begin
                ea = exp_a.pop_front();
                if (mem_addr !== ea) begin
                    n_fail++;
                    $display("FAIL addr: actual %0h required %0h", mem_addr, ea);
                end
            end
        end
    end

    function automatic logic [1:0] pix_exp(int l, int x);
        int         b = (int'(BASE) + l * 40 + x / 4) & 255;
        logic [1:0] p = 2'((b >> (6 - 2 * (x % 4))) & 3);
`ifdef DMG_LCD_FETCH_PALETTE_EN
        return 2'((int'(PAL) >> (2 * p)) & 3);
`else
        return p;
`endif
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk_8m);
        #1;
    endtask

    task automatic chk(int kind, logic [15:0] val, string name);
        exp_q.push_back('{kind, val, 0, name});
    endtask

    task automatic push_line(int l);
        for (int i = 0; i < 40; i++) exp_a.push_back(16'(int'(BASE) + l * 40 + i));
    endtask

    task automatic wait_a(int bound, string name);
        for (int i = 0; i < bound && exp_a.size() > 0; i++) step(1);
        if (exp_a.size() > 0) begin
            exp_q.push_back('{K_TO, 16'd0, exp_a.size(), name});
            exp_a.delete();
        end
    endtask

    task automatic pix_at(int x, int y, logic [1:0] e, string name);
        cur_xpos = 8'(x);
        cur_ypos = 8'(y);
        step(1);
        chk(K_PIX, {14'd0, e}, name);
    endtask

    task automatic run_line(int y, int x, bit check);
        int t = (y == 170) ? 0 : (y + 1 < 160) ? y + 1 : -1;
        if (t >= 0) push_line(t);
        cur_ypos = 8'(y);
        cur_xpos = 8'(x);
        step(45);
        if (check && y < 160) chk(K_PIX, {14'd0, pix_exp(y, x)}, "frame pix");
        if (check && y >= 160 && y < 170) chk(K_REQ, 16'd0, "blank req");
        step(5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cur_xpos = 8'd200; cur_ypos = 8'd0; underrun_clr = 1'b0; palette = PAL;
        step(2);
        chk(K_REQ, 16'd0, "reset req");
        chk(K_ADDR, 16'd0, "reset addr");
        chk(K_PIX, 16'd3, "reset pix");
        chk(K_UND, 16'd0, "reset underrun");
        step(1);
        push_line(0);
        rst = 1'b0;
        step(1);
        chk(K_REQ, 16'd1, "boot req");
        wait_a(100, "line0 fetch");
        pix_at(0, 0, pix_exp(0, 0), "l0 x0");
        pix_at(7, 0, pix_exp(0, 7), "l0 x7");
        pix_at(157, 0, pix_exp(0, 157), "l0 x157");
        pix_at(160, 0, 2'b11, "l0 out of area");
        chk(K_UND, 16'd0, "l0 underrun");
        for (int y = 1; y <= 170; y++) run_line(y, 200, 1'b0);
        wait_a(100, "frame1");
        for (int y = 0; y <= 170; y++) run_line(y, (y < 160) ? (y * 7) % 160 : 200, 1'b1);
        wait_a(100, "frame2");
        chk(K_UND, 16'd0, "frame underrun");
        // slow memory: line 1 cannot complete, then line 2 displaces it mid-request
        chk_addr = 1'b0; lat = 30; cur_xpos = 8'd0; cur_ypos = 8'd0;
        step(3);
        chk(K_UND, 16'd0, "slow l0 underrun");
        chk(K_PIX, {14'd0, pix_exp(0, 0)}, "slow l0 pix");
        k = 0;
        for (int i = 0; i < 300 && k < 3; i++) begin
            @(negedge clk_8m);
            if (mem_ack) k++;
        end
        if (k < 3) exp_q.push_back('{K_TO, 16'd3, k, "slow acks"});
        @(posedge clk_8m); #1;
        step(4);
        chk_addr = 1'b1;
        exp_a.push_back(BASE + 16'd43);
        push_line(2);
        cur_ypos = 8'd1;
        step(1);
        chk(K_UND, 16'd1, "l1 underrun");
        chk(K_PIX, 16'd3, "l1 not ready pix");
        chk(K_REQ, 16'd1, "drain req");
        step(5);
        chk(K_REQ, 16'd1, "drain req held");
        cur_xpos = 8'd200; underrun_clr = 1'b1;
        step(1);
        underrun_clr = 1'b0;
        chk(K_UND, 16'd0, "underrun clr");
        cur_xpos = 8'd0; underrun_clr = 1'b1;
        step(1);
        underrun_clr = 1'b0; cur_xpos = 8'd200;
        chk(K_UND, 16'd1, "set beats clr");
        for (int i = 0; i < 100 && exp_a.size() > 40; i++) step(1);
        if (exp_a.size() > 40) exp_q.push_back('{K_TO, 16'd40, exp_a.size(), "drain ack"});
        lat = 0;
        wait_a(200, "line2");
        push_line(3);
        cur_xpos = 8'd0; cur_ypos = 8'd2;
        step(2);
        chk(K_PIX, {14'd0, pix_exp(2, 0)}, "l2 x0");
        pix_at(5, 2, pix_exp(2, 5), "l2 x5");
        wait_a(200, "line3");
        // reset during an outstanding request
        chk_addr = 1'b0; lat = 5; cur_xpos = 8'd200; cur_ypos = 8'd3;
        step(10);
        chk(K_REQ, 16'd1, "req before rst");
        step(1);
        #2 rst = 1'b1;
        chk(K_REQ, 16'd0, "rst req");
        chk(K_PIX, 16'd3, "rst pix");
        chk(K_UND, 16'd0, "rst underrun");
        chk(K_ADDR, 16'd0, "rst addr");
        cur_ypos = 8'd0;
        step(2);
        chk_addr = 1'b1; lat = 0;
        push_line(0);
        rst = 1'b0;
        step(1);
        chk(K_REQ, 16'd1, "reboot req");
        wait_a(100, "refetch line0");
        pix_at(0, 0, pix_exp(0, 0), "re x0");
        pix_at(7, 0, pix_exp(0, 7), "re x7");
        pix_at(157, 0, pix_exp(0, 157), "re x157");
        pix_at(200, 0, 2'b11, "re out of area");
        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
